// File: rtl/dotmatrix_scan_ctrl.sv
// dotmatrix_scan_ctrl: row-scan controller for a 16x16 LED matrix with frame-aligned glyph switching.
module dotmatrix_scan_ctrl #(
    parameter int SCAN_DIV         = 4,
    parameter int FRAMES_PER_GLYPH = 50,
    parameter int NUM_GLYPHS       = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        hold,
    input  logic        load,
    input  logic [3:0]  load_idx,
    input  logic [15:0] col_in,
    output logic [3:0]  row_bin,
    output logic [3:0]  glyph_idx,
    output logic [15:0] row_oh,
    output logic [15:0] col_out,
    output logic        frame_done
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int FW = $clog2(FRAMES_PER_GLYPH + 1);
    localparam logic [1:0] IDLE = 2'd0, BLANK = 2'd1, DRIVE = 2'd2;

    logic [1:0]    state;
    logic [DW-1:0] div;
    logic [FW-1:0] fc;
    logic [3:0]    pend;
    logic          pend_v;
    logic          last, boundary, fc_top;
    logic [3:0]    ld_val, glyph_next;

    always_comb begin
        last       = state == DRIVE && div == DW'(SCAN_DIV - 2);
        boundary   = last && row_bin == 4'd15;
        fc_top     = fc == FW'(FRAMES_PER_GLYPH - 1);
        ld_val     = load_idx > 4'(NUM_GLYPHS - 1) ? 4'(NUM_GLYPHS - 1) : load_idx;
        glyph_next = glyph_idx == 4'(NUM_GLYPHS - 1) ? 4'd0 : glyph_idx + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            div        <= '0;
            fc         <= '0;
            pend       <= '0;
            pend_v     <= 1'b0;
            row_bin    <= '0;
            glyph_idx  <= '0;
            row_oh     <= '0;
            col_out    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= en && boundary;
            if (!en) begin
                state   <= IDLE;
                row_bin <= '0;
                row_oh  <= '0;
                col_out <= '0;
                div     <= '0;
            end else if (state == IDLE) begin
                state   <= BLANK;
                row_bin <= '0;
            end else if (state == BLANK) begin
                state   <= DRIVE;
                col_out <= col_in;
                row_oh  <= 16'b1 << row_bin;
                div     <= '0;
            end else if (last) begin
                state   <= BLANK;
                row_bin <= row_bin + 4'd1;
                row_oh  <= '0;
                col_out <= '0;
            end else if (state == DRIVE) begin
                div <= div + DW'(1);
            end else begin
                state <= IDLE;
            end
            // Glyph changes only while idle or exactly at a frame boundary, so a frame never tears.
            if ((state == IDLE || (en && boundary)) && pend_v) begin
                glyph_idx <= pend;
                pend_v    <= 1'b0;
                fc        <= '0;
            end else if (en && boundary) begin
                if (!fc_top) begin
                    fc <= fc + FW'(1);
                end else if (!hold) begin
                    glyph_idx <= glyph_next;
                    fc        <= '0;
                end
            end
            // A load coinciding with the boundary survives the clear above and waits for the next one.
            if (load) begin
                pend   <= ld_val;
                pend_v <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dotmatrix_scan_ctrl.sv
// tb_dotmatrix_scan_ctrl: table vectors, directed corner sequences and a frame-position reference model.
module tb_dotmatrix_scan_ctrl;
    localparam int SD = 4, FPG = 2, NG = 10, FRAME = 16 * SD;

    logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, hold = 1'b0, load = 1'b0;
    logic [3:0]  load_idx = '0;
    logic [15:0] col_in;
    logic [3:0]  row_bin, glyph_idx;
    logic [15:0] row_oh, col_out;
    logic        frame_done;

    dotmatrix_scan_ctrl #(.SCAN_DIV(SD), .FRAMES_PER_GLYPH(FPG), .NUM_GLYPHS(NG)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .hold(hold), .load(load), .load_idx(load_idx),
        .col_in(col_in), .row_bin(row_bin), .glyph_idx(glyph_idx), .row_oh(row_oh),
        .col_out(col_out), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom(input logic [3:0] g, input logic [3:0] r);
        return (g == 4'd7 && r == 4'd1) ? 16'h0FF0 : {g, r, ~g, ~r};
    endfunction
    assign col_in = rom(glyph_idx, row_bin);

    int errs = 0, checks = 0;
    bit mchk = 0;

    // Reference: the scan is a single position t within the frame plus an idle flag.
    bit         m_idle = 1, m_pv = 0, m_fd = 0;
    int         m_t = 0, m_fc = 0;
    logic [3:0] m_g = '0, m_p = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset;
        m_idle = 1; m_pv = 0; m_fd = 0; m_t = 0; m_fc = 0; m_g = '0; m_p = '0;
    endtask

    task automatic model_next;
        bit bnd;
        if (!rst_n) begin
            model_reset();
            return;
        end
        bnd = !m_idle && m_t == FRAME - 1;
        if ((m_idle || (en && bnd)) && m_pv) begin
            m_g = m_p; m_pv = 0; m_fc = 0;
        end else if (en && bnd) begin
            if (m_fc < FPG - 1) m_fc++;
            else if (!hold) begin
                m_g = (m_g == 4'(NG - 1)) ? 4'd0 : m_g + 4'd1;
                m_fc = 0;
            end
        end
        m_fd = en && bnd;
        if (!en) begin m_idle = 1; m_t = 0; end
        else if (m_idle) begin m_idle = 0; m_t = 0; end
        else m_t = (m_t + 1) % FRAME;
        if (load) begin
            m_p = (load_idx > 4'(NG - 1)) ? 4'(NG - 1) : load_idx;
            m_pv = 1;
        end
    endtask

    task automatic model_cmp;
        int row;
        bit drv;
        row = m_idle ? 0 : m_t / SD;
        drv = !m_idle && (m_t % SD) != 0;
        chk("rand", {row_bin, glyph_idx, row_oh, col_out, frame_done},
            {4'(row), m_g, drv ? 16'(1 << row) : 16'h0, drv ? rom(m_g, 4'(row)) : 16'h0, m_fd});
    endtask

    task automatic step;
        model_next();
        @(posedge clk);
        #1;
        if (mchk) model_cmp();
    endtask

    task automatic wait_fd;
        int n = 0;
        do begin step(); n++; end while (!frame_done && n < 200);
        chk("fd_wait", 64'(frame_done), 64'd1);
    endtask

    typedef struct {
        logic        en;
        logic [3:0]  rb;
        logic [15:0] oh;
        logic [15:0] col;
    } vec_t;
    vec_t tbl[10];

    initial begin
        tbl[0] = '{1'b1, 4'd0, 16'h0000, 16'h0000};
        tbl[1] = '{1'b1, 4'd0, 16'h0001, 16'h00FF};
        tbl[2] = '{1'b1, 4'd0, 16'h0001, 16'h00FF};
        tbl[3] = '{1'b1, 4'd0, 16'h0001, 16'h00FF};
        tbl[4] = '{1'b1, 4'd1, 16'h0000, 16'h0000};
        tbl[5] = '{1'b1, 4'd1, 16'h0002, 16'h01FE};
        tbl[6] = '{1'b1, 4'd1, 16'h0002, 16'h01FE};
        tbl[7] = '{1'b1, 4'd1, 16'h0002, 16'h01FE};
        tbl[8] = '{1'b1, 4'd2, 16'h0000, 16'h0000};
        tbl[9] = '{1'b0, 4'd0, 16'h0000, 16'h0000};

        #12;
        chk("reset", {row_bin, glyph_idx, row_oh, col_out, frame_done}, 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            en = tbl[i].en;
            step();
            chk($sformatf("vec%0d", i), {row_bin, row_oh, col_out, frame_done},
                {tbl[i].rb, tbl[i].oh, tbl[i].col, 1'b0});
        end

        en = 1'b1;
        step();
        step();
        #2 rst_n = 1'b0;
        #1 chk("async_rst", {row_bin, glyph_idx, row_oh, col_out, frame_done}, 64'd0);
        step();
        rst_n = 1'b1;
        for (int r = 0; r < 16; r++) begin
            step();
            chk("scan_blank", {row_bin, row_oh}, {4'(r), 16'h0});
            for (int k = 0; k < SD - 1; k++) begin
                step();
                chk("scan_drive", {row_bin, row_oh}, {4'(r), 16'(1 << r)});
            end
        end
        step();
        chk("first_fd", {frame_done, glyph_idx, row_oh}, {1'b1, 4'd0, 16'h0});

        en = 1'b0; load = 1'b1; load_idx = 4'd7;
        step();
        load = 1'b0;
        step();
        chk("idle_load", 64'(glyph_idx), 64'd7);
        en = 1'b1;
        repeat (SD + 1) step();
        chk("col_blank", {row_oh, col_out}, 32'h0);
        step();
        chk("col_capture", {row_oh, col_out}, {16'h0002, 16'h0FF0});

        en = 1'b0; load = 1'b1; load_idx = 4'd9;
        step();
        load = 1'b0;
        step();
        en = 1'b1;
        wait_fd();
        chk("wrap_first", 64'(glyph_idx), 64'd9);
        wait_fd();
        chk("wrap_second", 64'(glyph_idx), 64'd0);

        en = 1'b0; load = 1'b1; load_idx = 4'd9;
        step();
        load = 1'b0;
        step();
        hold = 1'b1; en = 1'b1;
        repeat (4) begin
            wait_fd();
            chk("hold", 64'(glyph_idx), 64'd9);
        end
        hold = 1'b0;
        wait_fd();
        chk("hold_release", 64'(glyph_idx), 64'd0);

        wait_fd();
        chk("pre_sim", 64'(glyph_idx), 64'd0);
        repeat (FRAME - 1) step();
        chk("boundary_row", {row_bin, row_oh}, {4'd15, 16'h8000});
        load = 1'b1; load_idx = 4'd4;
        step();
        load = 1'b0;
        chk("sim_auto", {frame_done, glyph_idx}, {1'b1, 4'd1});
        wait_fd();
        chk("sim_pending", 64'(glyph_idx), 64'd4);

        repeat (5 * SD) step();
        load = 1'b1; load_idx = 4'd3;
        step();
        load = 1'b0;
        chk("load_hold_mid", 64'(glyph_idx), 64'd4);
        wait_fd();
        chk("load3", 64'(glyph_idx), 64'd3);
        repeat (8 * SD) step();
        load = 1'b1; load_idx = 4'd12;
        step();
        load = 1'b0;
        wait_fd();
        chk("load_sat", 64'(glyph_idx), 64'd9);

        repeat (10 * SD + 1) step();
        chk("row10", 64'(row_bin), 64'd10);
        en = 1'b0;
        step();
        chk("en_drop", {row_bin, row_oh, col_out, frame_done, glyph_idx}, {4'd0, 16'h0, 16'h0, 1'b0, 4'd9});
        en = 1'b1;
        step();
        chk("reen_blank", {row_bin, row_oh}, {4'd0, 16'h0});
        step();
        chk("reen_drive", {row_oh, col_out}, {16'h0001, 16'h906F});

        rst_n = 1'b0; en = 1'b0;
        step();
        rst_n = 1'b1;
        mchk = 1;
        for (int i = 0; i < 4000; i++) begin
            en = $urandom_range(0, 199) != 0;
            load = $urandom_range(0, 59) == 0;
            load_idx = 4'($urandom);
            if ($urandom_range(0, 299) == 0) hold = ~hold;
            step();
        end
        mchk = 0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/dotmatrix_scan_ctrl.md
# dotmatrix_scan_ctrl

Row-scan controller for the 16x16 LED dot-matrix display. It walks `row_bin` through rows 0..15 and drives the one-hot row enable. It registers the column word returned by the glyph ROMs (one ROM per digit, muxed externally by `glyph_idx`). It advances the displayed digit automatically every N frames, or on a frame-aligned manual load. It sits between the top-level clock/reset and the per-digit pattern ROMs.

## Interface
- `SCAN_DIV`, default 4: clock cycles per row; minimum 2. Each row gets 1 blank cycle plus `SCAN_DIV`-1 drive cycles.
- `FRAMES_PER_GLYPH`, default 50: full frames shown before auto-advance; minimum 1.
- `NUM_GLYPHS`, default 10: number of glyph ROMs; `glyph_idx` wraps at `NUM_GLYPHS`-1.
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: scan enable, level-sensitive.
- `hold` input 1: when high, auto-advance is suppressed; scanning continues.
- `load` input 1: single-cycle request to switch glyph.
- `load_idx` input 4: requested glyph, sampled when `load`=1.
- `col_in` input 16: column word from the muxed glyph ROM, combinational in `row_bin` and `glyph_idx`.
- `row_bin` output 4: current row address to the ROMs, registered.
- `glyph_idx` output 4: current glyph select, registered.
- `row_oh` output 16: active-high one-hot row enable. Equals `16'b1 << row_bin` during DRIVE, otherwise 0.
- `col_out` output 16: registered column drive, active-high.
- `frame_done` output 1: one-cycle pulse at the end of row 15 drive.

## Operation
- Reset values: state IDLE, `row_bin`=0, `glyph_idx`=0, `row_oh`=0, `col_out`=0, `frame_done`=0. Frame counter, divider counter and pending-valid flag are all 0.
- FSM states:
  - IDLE: all drives off. `en`=1 moves to BLANK with `row_bin`=0.
  - BLANK: exactly 1 cycle; `row_oh`=0 and `col_out`=0. ROM output settles. Then go to DRIVE, loading `col_out`<=`col_in` and setting `row_oh`.
  - DRIVE: `SCAN_DIV`-1 cycles; `col_out` is held stable. On the last cycle, `row_bin` increments mod 16 and the FSM returns to BLANK.
- Frame boundary is the last DRIVE cycle of row 15. In that cycle:
  - `frame_done` pulses in the following cycle (registered).
  - If pending-valid: `glyph_idx`<=pending, pending-valid<=0, frame counter<=0.
  - Else if frame counter = `FRAMES_PER_GLYPH`-1 and `hold`=0: `glyph_idx`<=(`glyph_idx`=`NUM_GLYPHS`-1 ? 0 : `glyph_idx`+1), frame counter<=0.
  - Else if frame counter = `FRAMES_PER_GLYPH`-1 and `hold`=1: frame counter saturates at `FRAMES_PER_GLYPH`-1, so advance happens at the first boundary after `hold` drops.
  - Otherwise frame counter increments.
- `load` in any state latches pending<=min(`load_idx`, `NUM_GLYPHS`-1) and sets pending-valid.
  - A later `load` before the boundary overwrites the pending value (last wins).
  - A `load` in the same cycle as the frame boundary is captured as pending and applies at the next boundary.
- In IDLE, a pending load applies immediately on the next cycle, since no frame is in progress.
- `glyph_idx` never changes mid-frame; this prevents tearing.
- Deassert of `en` in any state: next cycle enters IDLE.
  - `row_bin`<=0, `row_oh`=0, `col_out`=0, divider counter<=0.
  - Frame counter, `glyph_idx` and pending are retained.
  - No `frame_done` is generated for an aborted frame.
- `rst_n` low at any time forces the reset values asynchronously. The first scan after release starts at row 0, glyph 0.

## Timing
- `en` rises at cycle 0: IDLE→BLANK at edge 1. First DRIVE of row 0 starts at edge 2, with `col_out` valid from edge 2.
- Row period is `SCAN_DIV` cycles. Frame period is 16·`SCAN_DIV` cycles. Glyph period is `FRAMES_PER_GLYPH`·16·`SCAN_DIV` cycles.
- `col_in` is sampled in the BLANK cycle (one full cycle after the `row_bin` change), and is registered at the BLANK→DRIVE edge.
- `row_oh` and `col_out` change only at BLANK entry (both go to 0) and at DRIVE entry. There is no glitch between rows.
- `frame_done` is high for exactly 1 cycle, one cycle after the row-15 last DRIVE cycle. It coincides with BLANK of row 0 and with the new `glyph_idx`.

## Test plan
- Reset/enable:
  - Stimulus: `SCAN_DIV`=4; assert `rst_n`=0 mid-DRIVE, then release with `en`=1.
  - Required: all outputs 0 during reset. After release, `row_bin`=0, BLANK for 1 cycle, then `row_oh`=16'h0001 for 3 cycles. Rows advance every 4 cycles through 16'h8000.
- Column capture:
  - Stimulus: `glyph_idx`=7 stub ROM, row 1 `col_in`=16'h0FF0.
  - Required: during row 1 DRIVE, `col_out`=16'h0FF0 and `row_oh`=16'h0002. During BLANK, both are 0.
- Auto-advance and wrap:
  - Stimulus: `FRAMES_PER_GLYPH`=2, `NUM_GLYPHS`=10, start with `glyph_idx`=9.
  - Required: after 2 `frame_done` pulses, `glyph_idx`=0, changing exactly with the second pulse. With `hold`=1 it stays 9 indefinitely, then advances at the first boundary after `hold`=0.
- Manual load:
  - Stimulus: `load`=1, `load_idx`=3 at row 5; then `load_idx`=12 at row 8 of the next frame.
  - Required: `glyph_idx` stays unchanged until the frame boundary, then becomes 3 and the frame counter resets. The second load saturates, giving `glyph_idx`=9 at the following boundary.
- Enable drop mid-frame:
  - Stimulus: `en`=0 at row 10.
  - Required: next cycle `row_oh`=0, `col_out`=0, `row_bin`=0, no `frame_done`, `glyph_idx` retained. Re-enable restarts at row 0 with 1 BLANK cycle.
- Simultaneous load and boundary:
  - Stimulus: `load` with `load_idx`=4 in the row-15 last DRIVE cycle while auto-advance is due.
  - Required: auto-advance occurs at this boundary. `glyph_idx`=4 is applied at the next boundary.
